game_board_ctrl: RTL and testbench
==================================

GAME_BOARD_CTRL -- requirements
Module: game_board_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, board dimension (legal range 3..8); a line is N cells and a game has N*N cells.
REQ-002 SHALL have parameter IDX_W, default 3, width of the row/column indices; it must satisfy 2**IDX_W >= N.
REQ-003 SHALL have port iCLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port iRST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have ports iUp, iDown, iLeft, iRight  input  1 each  debounced single-cycle cursor pulses.
REQ-006 SHALL have ports iPlace and iNewGame  input  1 each  single-cycle pulses that place a mark and restart the game.
REQ-007 SHALL have ports iRd_row and iRd_col  input  IDX_W each  renderer read address.
REQ-008 SHALL have port oRd_cell  output  2  contents of the cell at the read address.
REQ-009 SHALL have ports oCur_row and oCur_col  output  IDX_W each  cursor position.
REQ-010 SHALL have port oTurn  output  2  the player to move.
REQ-011 SHALL have port oWinner  output  2  the winning player.
REQ-012 SHALL have port oState  output  2  FSM state.
REQ-013 SHALL have port oErr  output  1  one-cycle pulse on a rejected placement.

Function
REQ-014 SHALL encode cells as 00 empty, 01 X, 10 O; code 11 is never stored.
REQ-015 SHALL implement FSM states PLAY=00, CHECK=01, WIN=10, DRAW=11, visible on oState.
REQ-016 SHALL move the cursor only in PLAY, with wrap-around in each axis: iUp at row 0 goes to row N-1, iDown at row N-1 goes to row 0, and iLeft/iRight behave the same on columns.
REQ-017 SHALL cancel opposing pulses: iUp+iDown in the same cycle leaves the row unchanged, and iLeft+iRight in the same cycle leaves the column unchanged; a vertical and a horizontal pulse in the same cycle both apply.
REQ-018 SHALL, on iPlace in PLAY at an empty cell, write oTurn into the cell at the pre-move cursor position on the next edge, then enter CHECK.
REQ-019 SHALL, on iPlace in PLAY at an occupied cell, leave the board, turn and state unchanged and pulse oErr high for exactly one cycle.
REQ-020 SHALL, in CHECK, scan the four lines through the placed cell (its row, its column, the main diagonal and the anti-diagonal) at one cell per cycle; CHECK lasts exactly 4N cycles.
REQ-021 SHALL treat a diagonal as non-matching when the placed cell does not lie on it (main: r==c; anti: r+c==N-1), while still consuming its N cycles.
REQ-022 SHALL, at the end of CHECK, go to WIN with oWinner = the placed mark if any line fully matches the placed mark.
REQ-023 SHALL otherwise go to DRAW when the move count equals N*N.
REQ-024 SHALL otherwise toggle oTurn (01 <-> 10) and return to PLAY.
REQ-025 SHALL give cycle timing as: iPlace sampled at edge t, oState=CHECK from t+1 through t+4N, and the final state at t+4N+1.
REQ-026 SHALL ignore iPlace and the cursor pulses in CHECK, WIN and DRAW.
REQ-027 SHALL give iNewGame priority over every other input in every state, including aborting CHECK: on the next edge all cells are 00, cursor (0,0), oTurn=01, oWinner=00, move count 0, state PLAY.
REQ-028 SHALL register oRd_cell with one cycle of latency, and return 00 for an out-of-range address (row or column >= N).
REQ-029 SHALL hold oWinner at 00 in every state except WIN.

Reset
REQ-030 SHALL, while iRST is high, drive oState=PLAY, oTurn=01, oWinner=00, oCur_row=oCur_col=0, oErr=0, oRd_cell=00, all cells 00 and the move count and scan counters 0.
REQ-031 SHALL ignore all inputs while iRST is high, and accept inputs from the first edge after release.

Structure
REQ-032 SHALL place the cell encoding constants and the FSM state encodings in the shared package game_pkg.
REQ-033 SHALL use one sub-module, board_regs: an N*N x 2-bit register file with one synchronous write port, one registered render read port and one combinational checker read port.

Verification
REQ-034 SHALL cover a row win (N=3): X(0,0), O(1,0), X(0,1), O(1,1), X(0,2) -> 12 cycles after the last iPlace, oState=WIN and oWinner=01.
REQ-035 SHALL cover a draw (N=3): nine placements with no line completed -> oState=DRAW and oWinner=00.
REQ-036 SHALL cover an occupied cell: after reset, iPlace at (0,0) and, once back in PLAY, iPlace at (0,0) again -> single-cycle oErr, oTurn stays 10, cell (0,0) stays 01.
REQ-037 SHALL cover wrap-around: from reset, iLeft -> column 2; then iUp -> row 2; then iUp+iDown together -> row 2 unchanged.
REQ-038 SHALL cover an abort: iNewGame at the 3rd cycle of CHECK -> next cycle oState=PLAY, and reading every cell returns 00.
REQ-039 SHALL cover an anti-diagonal win (N=4): X at (0,3), (1,2), (2,1), (3,0) interleaved with non-winning O moves -> 16 cycles after the last iPlace, oState=WIN and oWinner=01.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the game board controller: cell contents, FSM states
// and the order in which the checker walks the lines through the last move.
package game_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_WIN   = 2'b10,
    ST_DRAW  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    LINE_ROW  = 2'b00,
    LINE_COL  = 2'b01,
    LINE_DIAG = 2'b10,
    LINE_ANTI = 2'b11
  } line_e;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == CELL_X) ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/board_regs.sv
// N*N x 2-bit board storage: one synchronous write port (with whole-board
// clear), one registered render read port and one combinational checker port.
module board_regs
  import game_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_row,
  input  logic [IDX_W-1:0] wr_col,
  input  logic [1:0]       wr_data,
  input  logic [IDX_W-1:0] rd_row,
  input  logic [IDX_W-1:0] rd_col,
  output logic [1:0]       rd_data,
  input  logic [IDX_W-1:0] chk_row,
  input  logic [IDX_W-1:0] chk_col,
  output logic [1:0]       chk_data
);

  localparam int CELLS = N * N;
  localparam int AW    = $clog2(CELLS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [1:0] cells_q [CELLS];
  logic [1:0] cells_d [CELLS];
  logic [1:0] rd_data_q, rd_data_d;

  function automatic logic [AW-1:0] cell_idx(input logic [IDX_W-1:0] r,
                                             input logic [IDX_W-1:0] c);
    int flat;
    flat = int'(r) * N + int'(c);
    return AW'(flat);
  endfunction

  always_comb begin
    cells_d = cells_q;
    if (clr) begin
      for (int unsigned i = 0; i < CELLS; i++) cells_d[i] = CELL_EMPTY;
    end else if (we) begin
      cells_d[cell_idx(wr_row, wr_col)] = wr_data;
    end
    // Range check keeps an out-of-board address from aliasing onto a real cell.
    rd_data_d = CELL_EMPTY;
    if (rd_row <= LAST && rd_col <= LAST) rd_data_d = cells_q[cell_idx(rd_row, rd_col)];
  end

  assign chk_data = cells_q[cell_idx(chk_row, chk_col)];
  assign rd_data  = rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CELLS; i++) cells_q[i] <= CELL_EMPTY;
      rd_data_q <= CELL_EMPTY;
    end else begin
      cells_q   <= cells_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/game_board_ctrl.sv
// N x N tic-tac-toe style board controller: cursor, placement, a one-cell-per-
// cycle win checker over the four lines through the last move, and game end.
module game_board_ctrl
  import game_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 3
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iUp,
  input  logic             iDown,
  input  logic             iLeft,
  input  logic             iRight,
  input  logic             iPlace,
  input  logic             iNewGame,
  input  logic [IDX_W-1:0] iRd_row,
  input  logic [IDX_W-1:0] iRd_col,
  output logic [1:0]       oRd_cell,
  output logic [IDX_W-1:0] oCur_row,
  output logic [IDX_W-1:0] oCur_col,
  output logic [1:0]       oTurn,
  output logic [1:0]       oWinner,
  output logic [1:0]       oState,
  output logic             oErr
);

  localparam int MW = $clog2(N * N + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [MW-1:0]    FULL = MW'(N * N);

  state_e           state_q, state_d;
  logic [1:0]       turn_q, turn_d;
  logic [1:0]       winner_q, winner_d;
  logic [IDX_W-1:0] cur_row_q, cur_row_d;
  logic [IDX_W-1:0] cur_col_q, cur_col_d;
  logic             err_q, err_d;
  logic [MW-1:0]    moves_q, moves_d;
  logic [IDX_W-1:0] pr_q, pr_d;
  logic [IDX_W-1:0] pc_q, pc_d;
  line_e            line_q, line_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic             match_q, match_d;
  logic             found_q, found_d;

  logic             we, clr;
  logic [IDX_W-1:0] chk_row, chk_col;
  logic [1:0]       chk_data;
  logic             on_line, line_hit;

  board_regs #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_board (
    .clk      (iCLK),
    .rst      (iRST),
    .clr      (clr),
    .we       (we),
    .wr_row   (cur_row_q),
    .wr_col   (cur_col_q),
    .wr_data  (turn_q),
    .rd_row   (iRd_row),
    .rd_col   (iRd_col),
    .rd_data  (oRd_cell),
    .chk_row  (chk_row),
    .chk_col  (chk_col),
    .chk_data (chk_data)
  );

  always_comb begin
    state_d   = state_q;
    turn_d    = turn_q;
    winner_d  = winner_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    err_d     = 1'b0;
    moves_d   = moves_q;
    pr_d      = pr_q;
    pc_d      = pc_q;
    line_d    = line_q;
    pos_d     = pos_q;
    match_d   = match_q;
    found_d   = found_q;
    we        = 1'b0;
    clr       = 1'b0;
    line_hit  = 1'b0;

    // The checker port looks at the cursor in PLAY and at the scan cell in CHECK.
    chk_row = cur_row_q;
    chk_col = cur_col_q;
    on_line = 1'b1;
    if (state_q == ST_CHECK) begin
      unique case (line_q)
        LINE_ROW: begin
          chk_row = pr_q;
          chk_col = pos_q;
        end
        LINE_COL: begin
          chk_row = pos_q;
          chk_col = pc_q;
        end
        LINE_DIAG: begin
          chk_row = pos_q;
          chk_col = pos_q;
          on_line = (pr_q == pc_q);
        end
        LINE_ANTI: begin
          chk_row = pos_q;
          chk_col = LAST - pos_q;
          on_line = (({1'b0, pr_q} + {1'b0, pc_q}) == {1'b0, LAST});
        end
      endcase
    end

    if (iNewGame) begin
      clr       = 1'b1;
      state_d   = ST_PLAY;
      turn_d    = CELL_X;
      winner_d  = CELL_EMPTY;
      cur_row_d = '0;
      cur_col_d = '0;
      moves_d   = '0;
      line_d    = LINE_ROW;
      pos_d     = '0;
      match_d   = 1'b0;
      found_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          if (iUp && !iDown)
            cur_row_d = (cur_row_q == '0) ? LAST : cur_row_q - IDX_W'(1);
          else if (iDown && !iUp)
            cur_row_d = (cur_row_q == LAST) ? '0 : cur_row_q + IDX_W'(1);
          if (iLeft && !iRight)
            cur_col_d = (cur_col_q == '0) ? LAST : cur_col_q - IDX_W'(1);
          else if (iRight && !iLeft)
            cur_col_d = (cur_col_q == LAST) ? '0 : cur_col_q + IDX_W'(1);

          if (iPlace) begin
            if (chk_data == CELL_EMPTY) begin
              we      = 1'b1;
              moves_d = moves_q + MW'(1);
              pr_d    = cur_row_q;
              pc_d    = cur_col_q;
              line_d  = LINE_ROW;
              pos_d   = '0;
              match_d = 1'b1;
              found_d = 1'b0;
              state_d = ST_CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        ST_CHECK: begin
          line_hit = match_q && on_line && (chk_data == turn_q);
          if (pos_q == LAST) begin
            found_d = found_q | line_hit;
            match_d = 1'b1;
            pos_d   = '0;
            if (line_q == LINE_ANTI) begin
              line_d = LINE_ROW;
              if (found_q | line_hit) begin
                state_d  = ST_WIN;
                winner_d = turn_q;
              end else if (moves_q == FULL) begin
                state_d = ST_DRAW;
              end else begin
                state_d = ST_PLAY;
                turn_d  = other_player(turn_q);
              end
            end else begin
              line_d = line_e'(line_q + 2'd1);
            end
          end else begin
            match_d = line_hit;
            pos_d   = pos_q + IDX_W'(1);
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= ST_PLAY;
      turn_q    <= CELL_X;
      winner_q  <= CELL_EMPTY;
      cur_row_q <= '0;
      cur_col_q <= '0;
      err_q     <= 1'b0;
      moves_q   <= '0;
      pr_q      <= '0;
      pc_q      <= '0;
      line_q    <= LINE_ROW;
      pos_q     <= '0;
      match_q   <= 1'b0;
      found_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      turn_q    <= turn_d;
      winner_q  <= winner_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      err_q     <= err_d;
      moves_q   <= moves_d;
      pr_q      <= pr_d;
      pc_q      <= pc_d;
      line_q    <= line_d;
      pos_q     <= pos_d;
      match_q   <= match_d;
      found_q   <= found_d;
    end
  end

  assign oState   = state_q;
  assign oTurn    = turn_q;
  assign oWinner  = winner_q;
  assign oCur_row = cur_row_q;
  assign oCur_col = cur_col_q;
  assign oErr     = err_q;

endmodule

// File: tb/tb_game_board_ctrl.sv
// Bench for game_board_ctrl: a 3x3 instance for cursor, error, row win, abort
// and draw games, and a 4x4 instance for an anti-diagonal win.
module tb_game_board_ctrl;

  localparam logic [5:0] B_UP = 6'h01;
  localparam logic [5:0] B_DN = 6'h02;
  localparam logic [5:0] B_LT = 6'h04;
  localparam logic [5:0] B_RT = 6'h08;
  localparam logic [5:0] B_PL = 6'h10;
  localparam logic [5:0] B_NG = 6'h20;

  localparam logic [1:0] S_PLAY  = 2'b00;
  localparam logic [1:0] S_CHECK = 2'b01;
  localparam logic [1:0] S_WIN   = 2'b10;
  localparam logic [1:0] S_DRAW  = 2'b11;
  localparam logic [1:0] MX      = 2'b01;
  localparam logic [1:0] MO      = 2'b10;

  typedef struct {
    logic [5:0] btn;
    logic [2:0] row;
    logic [2:0] col;
  } vec_t;

  typedef struct {
    int         sel;
    logic [1:0] exp;
    string      name;
  } rq_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] b3 = '0, b4 = '0;
  logic [2:0] rr3 = '0, rc3 = '0, rr4 = '0, rc4 = '0;
  logic [1:0] rd3, tu3, wi3, st3, rd4, tu4, wi4, st4;
  logic [2:0] cr3, cc3, cr4, cc4;
  logic       er3, er4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] mb [2][8][8];
  logic [1:0] mturn [2];
  int mcr [2];
  int mcc [2];
  rq_t rq [$];
  vec_t tbl [10];

  always #5 clk = ~clk;

  game_board_ctrl #(.N(3), .IDX_W(3)) u_d3 (
    .iCLK(clk), .iRST(rst), .iUp(b3[0]), .iDown(b3[1]), .iLeft(b3[2]), .iRight(b3[3]),
    .iPlace(b3[4]), .iNewGame(b3[5]), .iRd_row(rr3), .iRd_col(rc3), .oRd_cell(rd3),
    .oCur_row(cr3), .oCur_col(cc3), .oTurn(tu3), .oWinner(wi3), .oState(st3), .oErr(er3)
  );

  game_board_ctrl #(.N(4), .IDX_W(3)) u_d4 (
    .iCLK(clk), .iRST(rst), .iUp(b4[0]), .iDown(b4[1]), .iLeft(b4[2]), .iRight(b4[3]),
    .iPlace(b4[4]), .iNewGame(b4[5]), .iRd_row(rr4), .iRd_col(rc4), .oRd_cell(rd4),
    .oCur_row(cr4), .oCur_col(cc4), .oTurn(tu4), .oWinner(wi4), .oState(st4), .oErr(er4)
  );

  function automatic int dim(input int sel);
    return (sel == 0) ? 3 : 4;
  endfunction
  function automatic logic [1:0] f_st(input int sel);
    return (sel == 0) ? st3 : st4;
  endfunction
  function automatic logic [1:0] f_tu(input int sel);
    return (sel == 0) ? tu3 : tu4;
  endfunction
  function automatic logic [1:0] f_wi(input int sel);
    return (sel == 0) ? wi3 : wi4;
  endfunction
  function automatic logic f_er(input int sel);
    return (sel == 0) ? er3 : er4;
  endfunction
  function automatic logic [1:0] f_rd(input int sel);
    return (sel == 0) ? rd3 : rd4;
  endfunction
  function automatic logic [2:0] f_cr(input int sel);
    return (sel == 0) ? cr3 : cr4;
  endfunction
  function automatic logic [2:0] f_cc(input int sel);
    return (sel == 0) ? cc3 : cc4;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [5:0] b);
    if (sel == 0) b3 = b;
    else b4 = b;
  endtask

  task automatic press(input int sel, input logic [5:0] b);
    drive(sel, b);
    step();
    drive(sel, '0);
  endtask

  task automatic chk_status(input int sel, input string name, input logic [1:0] st,
                            input logic [1:0] tu, input logic [1:0] wi, input logic er);
    chk({name, "_state"}, 8'(f_st(sel)), 8'(st));
    chk({name, "_turn"}, 8'(f_tu(sel)), 8'(tu));
    chk({name, "_winner"}, 8'(f_wi(sel)), 8'(wi));
    chk({name, "_err"}, 8'(f_er(sel)), 8'(er));
  endtask

  task automatic chk_cursor(input int sel, input string name);
    chk({name, "_row"}, 8'(f_cr(sel)), 8'(mcr[sel]));
    chk({name, "_col"}, 8'(f_cc(sel)), 8'(mcc[sel]));
  endtask

  task automatic clear_model(input int sel);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[sel][r][c] = 2'b00;
    mturn[sel] = MX;
    mcr[sel] = 0;
    mcc[sel] = 0;
  endtask

  task automatic goto(input int sel, input int r, input int c);
    int n;
    n = dim(sel);
    while (mcr[sel] != r) begin
      press(sel, B_DN);
      mcr[sel] = (mcr[sel] + 1) % n;
    end
    while (mcc[sel] != c) begin
      press(sel, B_RT);
      mcc[sel] = (mcc[sel] + 1) % n;
    end
    chk_cursor(sel, "goto");
  endtask

  // Expected cell value is queued when the address is driven and checked when
  // the registered read port delivers it one edge later.
  task automatic read_cell(input int sel, input int r, input int c, input string name);
    int n;
    rq_t e;
    n = dim(sel);
    if (sel == 0) begin
      rr3 = 3'(r);
      rc3 = 3'(c);
    end else begin
      rr4 = 3'(r);
      rc4 = 3'(c);
    end
    rq.push_back('{sel: sel, exp: (r < n && c < n) ? mb[sel][r][c] : 2'b00, name: name});
    step();
    if (rq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: actual empty-queue required entry", name);
    end else begin
      e = rq.pop_front();
      chk(e.name, 8'(f_rd(e.sel)), 8'(e.exp));
    end
  endtask

  task automatic read_all(input int sel, input string name);
    for (int r = 0; r < dim(sel); r++)
      for (int c = 0; c < dim(sel); c++)
        read_cell(sel, r, c, $sformatf("%s_%0d_%0d", name, r, c));
  endtask

  task automatic new_game(input int sel, input logic [5:0] extra, input string name);
    press(sel, B_NG | extra);
    clear_model(sel);
    chk_status(sel, name, S_PLAY, MX, 2'b00, 1'b0);
    chk_cursor(sel, name);
  endtask

  // Place at (r,c); CHECK must hold for exactly 4N cycles, ignoring pulses.
  task automatic do_move(input int sel, input int r, input int c, input logic [1:0] fst,
                         input logic [1:0] fwin, input logic [1:0] fturn, input string name);
    int n;
    n = dim(sel);
    goto(sel, r, c);
    chk({name, "_preturn"}, 8'(f_tu(sel)), 8'(mturn[sel]));
    mb[sel][r][c] = mturn[sel];
    press(sel, B_PL);
    chk({name, "_chk_first"}, 8'(f_st(sel)), 8'(S_CHECK));
    chk({name, "_chk_win0"}, 8'(f_wi(sel)), 8'(2'b00));
    for (int i = 0; i < 4 * n - 1; i++) begin
      if (i == 2) drive(sel, B_UP | B_LT | B_PL);
      step();
      drive(sel, '0);
    end
    chk({name, "_chk_last"}, 8'(f_st(sel)), 8'(S_CHECK));
    step();
    chk_status(sel, {name, "_end"}, fst, fturn, fwin, 1'b0);
    chk_cursor(sel, {name, "_end"});
    mturn[sel] = fturn;
  endtask

  initial begin
    clear_model(0);
    clear_model(1);
    tbl[0] = '{B_LT, 3'd0, 3'd2};
    tbl[1] = '{B_UP, 3'd2, 3'd2};
    tbl[2] = '{B_UP | B_DN, 3'd2, 3'd2};
    tbl[3] = '{B_LT | B_RT, 3'd2, 3'd2};
    tbl[4] = '{B_DN, 3'd0, 3'd2};
    tbl[5] = '{B_RT, 3'd0, 3'd0};
    tbl[6] = '{B_DN | B_RT, 3'd1, 3'd1};
    tbl[7] = '{B_UP | B_LT, 3'd0, 3'd0};
    tbl[8] = '{B_LT | B_RT | B_DN, 3'd1, 3'd0};
    tbl[9] = '{B_UP, 3'd0, 3'd0};

    // Reset: inputs are ignored while iRST is high.
    b3 = B_RT | B_DN | B_PL;
    repeat (2) step();
    chk_status(0, "rst3", S_PLAY, MX, 2'b00, 1'b0);
    chk_cursor(0, "rst3");
    chk("rst3_rd", 8'(rd3), 8'h00);
    chk_status(1, "rst4", S_PLAY, MX, 2'b00, 1'b0);
    chk("rst4_rd", 8'(rd4), 8'h00);
    b3 = '0;
    rst = 1'b0;

    // Cursor movement, wrap and cancellation vectors.
    for (int i = 0; i < 10; i++) begin
      press(0, tbl[i].btn);
      chk($sformatf("vec%0d_row", i), 8'(cr3), 8'(tbl[i].row));
      chk($sformatf("vec%0d_col", i), 8'(cc3), 8'(tbl[i].col));
      chk($sformatf("vec%0d_state", i), 8'(st3), 8'(S_PLAY));
      chk($sformatf("vec%0d_err", i), 8'(er3), 8'h0);
    end
    mcr[0] = 0;
    mcc[0] = 0;

    // Occupied cell.
    do_move(0, 0, 0, S_PLAY, 2'b00, MO, "occ_first");
    press(0, B_PL);
    chk_status(0, "occ_err", S_PLAY, MO, 2'b00, 1'b1);
    step();
    chk("occ_err_clear", 8'(er3), 8'h0);
    read_cell(0, 0, 0, "occ_cell00");

    // Row win.
    new_game(0, 6'h00, "ng1");
    do_move(0, 0, 0, S_PLAY, 2'b00, MO, "row_m1");
    do_move(0, 1, 0, S_PLAY, 2'b00, MX, "row_m2");
    do_move(0, 0, 1, S_PLAY, 2'b00, MO, "row_m3");
    do_move(0, 1, 1, S_PLAY, 2'b00, MX, "row_m4");
    do_move(0, 0, 2, S_WIN, MX, MX, "row_win");
    read_all(0, "row_rd");
    read_cell(0, 0, 3, "oob_0_3");
    read_cell(0, 3, 0, "oob_3_0");
    read_cell(0, 7, 7, "oob_7_7");
    press(0, B_PL | B_UP);
    chk_status(0, "win_hold", S_WIN, MX, MX, 1'b0);
    chk_cursor(0, "win_hold");

    // New game has priority over simultaneous pulses.
    new_game(0, B_PL | B_DN, "ng2");
    read_all(0, "ng2_rd");

    // Abort in the third cycle of CHECK.
    goto(0, 1, 1);
    mb[0][1][1] = MX;
    press(0, B_PL);
    chk("abort_chk1", 8'(st3), 8'(S_CHECK));
    step();
    step();
    chk("abort_chk3", 8'(st3), 8'(S_CHECK));
    new_game(0, B_UP | B_PL, "abort");
    read_all(0, "abort_rd");

    // Draw.
    do_move(0, 0, 0, S_PLAY, 2'b00, MO, "draw_m1");
    do_move(0, 0, 1, S_PLAY, 2'b00, MX, "draw_m2");
    do_move(0, 0, 2, S_PLAY, 2'b00, MO, "draw_m3");
    do_move(0, 1, 1, S_PLAY, 2'b00, MX, "draw_m4");
    do_move(0, 1, 0, S_PLAY, 2'b00, MO, "draw_m5");
    do_move(0, 2, 0, S_PLAY, 2'b00, MX, "draw_m6");
    do_move(0, 2, 1, S_PLAY, 2'b00, MO, "draw_m7");
    do_move(0, 1, 2, S_PLAY, 2'b00, MX, "draw_m8");
    do_move(0, 2, 2, S_DRAW, 2'b00, MX, "draw_end");
    press(0, B_PL);
    chk_status(0, "draw_hold", S_DRAW, MX, 2'b00, 1'b0);

    // Anti-diagonal win on the 4x4 board.
    do_move(1, 0, 3, S_PLAY, 2'b00, MO, "anti_m1");
    do_move(1, 0, 0, S_PLAY, 2'b00, MX, "anti_m2");
    do_move(1, 1, 2, S_PLAY, 2'b00, MO, "anti_m3");
    do_move(1, 0, 1, S_PLAY, 2'b00, MX, "anti_m4");
    do_move(1, 2, 1, S_PLAY, 2'b00, MO, "anti_m5");
    do_move(1, 1, 0, S_PLAY, 2'b00, MX, "anti_m6");
    do_move(1, 3, 0, S_WIN, MX, MX, "anti_win");
    read_cell(1, 0, 4, "oob4_0_4");
    read_cell(1, 1, 0, "anti_rd_1_0");
    read_cell(1, 2, 1, "anti_rd_2_1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
